windowed_energy_accumulator: RTL and testbench

Multi-channel successor to the single-channel energy block. It turns a stream of channel-tagged audio samples into one energy value per channel per window of DURATION samples. The magnitude mode is selectable: raw, absolute or squared. Accumulation saturates, and a flag reports any clipping in the window. Full valid/ready backpressure is supported on both sides. It sits between the sample source (ADC/decimator) and the clap-detection threshold logic.

---
 rtl/windowed_energy_accumulator.sv | 158 +++++++++++++++
 tb/tb_windowed_energy_accumulator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_energy_accumulator.sv
// Multi-channel windowed energy accumulator: per-channel saturating sums of
// |x|, x or x^2 over DURATION samples, with valid/ready on both sides.
module windowed_energy_accumulator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENERGY_WIDTH = 32,
    parameter int DURATION     = 16,
    parameter int CHANNELS     = 2,
    parameter int MODE         = 1,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [CH_W-1:0]         sample_channel,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [ENERGY_WIDTH-1:0] energy_data,
    output logic [CH_W-1:0]         energy_channel,
    output logic                    energy_saturated,
    output logic                    energy_valid,
    input  logic                    energy_ready
);

    localparam int MW    = 2 * SAMPLE_WIDTH;
    localparam int CNT_W = $clog2(DURATION);
    localparam int NSLOT = 1 << CH_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DURATION - 1);

    logic                    s1_valid_q, s1_valid_d;
    logic [MW-1:0]           s1_mag_q, s1_mag_d;
    logic [CH_W-1:0]         s1_ch_q, s1_ch_d;

    logic [ENERGY_WIDTH-1:0] acc_q [NSLOT];
    logic [ENERGY_WIDTH-1:0] acc_d [NSLOT];
    logic [CNT_W-1:0]        cnt_q [NSLOT];
    logic [CNT_W-1:0]        cnt_d [NSLOT];
    logic                    sat_q [NSLOT];
    logic                    sat_d [NSLOT];

    logic [ENERGY_WIDTH-1:0] e_data_q, e_data_d;
    logic [CH_W-1:0]         e_ch_q, e_ch_d;
    logic                    e_sat_q, e_sat_d;
    logic                    e_valid_q, e_valid_d;

    logic signed [MW-1:0]    s_ext;
    logic [MW-1:0]           mag_in;
    logic                    ch_ok;
    logic [ENERGY_WIDTH-1:0] mag_c;
    logic [ENERGY_WIDTH:0]   sum;
    logic                    clip;
    logic [ENERGY_WIDTH-1:0] stored;
    logic                    completing;
    logic                    out_free;
    logic                    s1_adv;

    assign s_ext = MW'($signed(sample_data));
    assign ch_ok = int'(32'(sample_channel)) < CHANNELS;

    always_comb begin
        mag_in = '0;
        if (MODE == 0) begin
            mag_in = MW'(sample_data);
        end else if (MODE == 1) begin
            mag_in = s_ext[MW-1] ? $unsigned(-s_ext) : $unsigned(s_ext);
        end else begin
            mag_in = $unsigned(s_ext * s_ext);
        end
    end

    // Squares can exceed the accumulator width; pin them to full scale.
    if (MW > ENERGY_WIDTH) begin : g_clamp
        assign mag_c = (|s1_mag_q[MW-1:ENERGY_WIDTH]) ? '1 : s1_mag_q[ENERGY_WIDTH-1:0];
    end else begin : g_extend
        assign mag_c = ENERGY_WIDTH'(s1_mag_q);
    end

    assign sum        = {1'b0, acc_q[s1_ch_q]} + {1'b0, mag_c};
    assign clip       = sum[ENERGY_WIDTH];
    assign stored     = clip ? '1 : sum[ENERGY_WIDTH-1:0];
    assign completing = s1_valid_q && (cnt_q[s1_ch_q] == LAST);
    assign out_free   = ~e_valid_q | energy_ready;
    // Only a completing sample facing an occupied output may stall stage 1.
    assign s1_adv     = ~(completing & ~out_free);

    assign sample_ready     = ~reset & s1_adv;
    assign energy_data      = e_data_q;
    assign energy_channel   = e_ch_q;
    assign energy_saturated = e_sat_q;
    assign energy_valid     = e_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mag_d   = s1_mag_q;
        s1_ch_d    = s1_ch_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        e_data_d   = e_data_q;
        e_ch_d     = e_ch_q;
        e_sat_d    = e_sat_q;
        e_valid_d  = e_valid_q;

        if (e_valid_q && energy_ready) begin
            e_valid_d = 1'b0;
        end

        if (s1_valid_q && s1_adv) begin
            if (completing) begin
                e_data_d       = stored;
                e_ch_d         = s1_ch_q;
                e_sat_d        = sat_q[s1_ch_q] | clip;
                e_valid_d      = 1'b1;
                acc_d[s1_ch_q] = '0;
                cnt_d[s1_ch_q] = '0;
                sat_d[s1_ch_q] = 1'b0;
            end else begin
                acc_d[s1_ch_q] = stored;
                cnt_d[s1_ch_q] = cnt_q[s1_ch_q] + CNT_W'(1);
                sat_d[s1_ch_q] = sat_q[s1_ch_q] | clip;
            end
        end

        if (s1_adv) begin
            s1_valid_d = sample_valid & ch_ok;
            if (sample_valid && ch_ok) begin
                s1_mag_d = mag_in;
                s1_ch_d  = sample_channel;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_ch_q    <= '0;
            acc_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            sat_q      <= '{default: 1'b0};
            e_data_q   <= '0;
            e_ch_q     <= '0;
            e_sat_q    <= 1'b0;
            e_valid_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mag_q   <= s1_mag_d;
            s1_ch_q    <= s1_ch_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            e_data_q   <= e_data_d;
            e_ch_q     <= e_ch_d;
            e_sat_q    <= e_sat_d;
            e_valid_q  <= e_valid_d;
        end
    end

endmodule

// File: tb/tb_windowed_energy_accumulator.sv
// Bench: four differently configured accumulators share one stimulus stream and
// are checked every cycle against a plain-arithmetic window/handshake model.
module tb_windowed_energy_accumulator;

    localparam int NI = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic [1:0]  s_ch;
    logic        s_valid;
    logic        e_ready;

    logic        rdy_w [NI];
    logic        val_w [NI];
    logic        sat_w [NI];
    logic [31:0] dat_w [NI];
    logic [1:0]  ch_w  [NI];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    function automatic int cfg_sw(int g);
        return (g == 2) ? 8 : 16;
    endfunction
    function automatic int cfg_ew(int g);
        case (g)
            2:       return 14;
            3:       return 16;
            default: return 32;
        endcase
    endfunction
    function automatic int cfg_d(int g);
        return (g < 2) ? 4 : 2;
    endfunction
    function automatic int cfg_ch(int g);
        case (g)
            0:       return 1;
            2:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int cfg_mode(int g);
        case (g)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_chw(int g);
        return (cfg_ch(g) > 1) ? $clog2(cfg_ch(g)) : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_i
        localparam int SW  = cfg_sw(g);
        localparam int EW  = cfg_ew(g);
        localparam int CHW = cfg_chw(g);
        logic [EW-1:0]  ed;
        logic [CHW-1:0] ec;
        logic           sr, ev, es;

        windowed_energy_accumulator #(
            .SAMPLE_WIDTH(SW),
            .ENERGY_WIDTH(EW),
            .DURATION(cfg_d(g)),
            .CHANNELS(cfg_ch(g)),
            .MODE(cfg_mode(g))
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .sample_data(s_data[SW-1:0]),
            .sample_channel(s_ch[CHW-1:0]),
            .sample_valid(s_valid),
            .sample_ready(sr),
            .energy_data(ed),
            .energy_channel(ec),
            .energy_saturated(es),
            .energy_valid(ev),
            .energy_ready(e_ready)
        );

        assign rdy_w[g] = sr;
        assign val_w[g] = ev;
        assign sat_w[g] = es;
        assign dat_w[g] = 32'(ed);
        assign ch_w[g]  = 2'(ec);
    end

    // Reference model state, per instance
    bit              m_s1v  [NI];
    longint unsigned m_s1mag[NI];
    int              m_s1ch [NI];
    longint unsigned m_acc  [NI][4];
    int              m_cnt  [NI][4];
    bit              m_sat  [NI][4];
    bit              m_ov   [NI];
    longint unsigned m_od   [NI];
    int              m_oc   [NI];
    bit              m_os   [NI];

    function automatic longint unsigned emax_of(int g);
        return (64'd1 << cfg_ew(g)) - 64'd1;
    endfunction

    function automatic longint unsigned mag_of(int g, logic [15:0] d);
        int              sw = cfg_sw(g);
        longint unsigned u  = 64'(d) & ((64'd1 << sw) - 64'd1);
        longint          s  = (u >= (64'd1 << (sw - 1))) ? longint'(u) - (longint'(1) << sw)
                                                         : longint'(u);
        longint unsigned m;
        case (cfg_mode(g))
            0:       m = u;
            1:       m = (s < 0) ? longint'(-s) : longint'(s);
            default: m = longint'(s * s);
        endcase
        return (m > emax_of(g)) ? emax_of(g) : m;
    endfunction

    function automatic bit m_ready(int g);
        if (reset) return 1'b0;
        return !(m_s1v[g] && m_cnt[g][m_s1ch[g]] == cfg_d(g) - 1 && m_ov[g] && !e_ready);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_s1v[g] = 0; m_s1mag[g] = 0; m_s1ch[g] = 0;
            m_ov[g] = 0; m_od[g] = 0; m_oc[g] = 0; m_os[g] = 0;
            for (int c = 0; c < 4; c++) begin
                m_acc[g][c] = 0; m_cnt[g][c] = 0; m_sat[g][c] = 0;
            end
        end
    endtask

    // Next state of every instance given the inputs the coming edge will see.
    task automatic model_advance();
        if (reset) begin
            model_reset();
            return;
        end
        for (int g = 0; g < NI; g++) begin
            bit              rdy = m_ready(g);
            int              ch  = int'(s_ch) & ((1 << cfg_chw(g)) - 1);
            int              c   = m_s1ch[g];
            longint unsigned sum, st;
            bit              clip;
            if (m_ov[g] && e_ready) m_ov[g] = 0;
            if (m_s1v[g] && rdy) begin
                sum  = m_acc[g][c] + m_s1mag[g];
                clip = sum > emax_of(g);
                st   = clip ? emax_of(g) : sum;
                if (m_cnt[g][c] == cfg_d(g) - 1) begin
                    m_od[g] = st; m_oc[g] = c; m_os[g] = m_sat[g][c] | clip; m_ov[g] = 1;
                    m_acc[g][c] = 0; m_cnt[g][c] = 0; m_sat[g][c] = 0;
                end else begin
                    m_acc[g][c] = st; m_cnt[g][c]++; m_sat[g][c] = m_sat[g][c] | clip;
                end
            end
            if (rdy) begin
                m_s1v[g] = s_valid && (ch < cfg_ch(g));
                if (m_s1v[g]) begin
                    m_s1mag[g] = mag_of(g, s_data);
                    m_s1ch[g]  = ch;
                end
            end
        end
    endtask

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NI; g++) begin
            chk("sample_ready", g, 64'(rdy_w[g]), 64'(m_ready(g)));
            chk("energy_valid", g, 64'(val_w[g]), 64'(m_ov[g]));
            if (m_ov[g]) begin
                chk("energy_data", g, 64'(dat_w[g]), m_od[g]);
                chk("energy_channel", g, 64'(ch_w[g]), 64'(m_oc[g]));
                chk("energy_saturated", g, 64'(sat_w[g]), 64'(m_os[g]));
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(negedge clock);
        #1;
        compare_all();
    endtask

    task automatic send(logic [15:0] d, logic [1:0] ch);
        s_valid = 1'b1;
        s_data  = d;
        s_ch    = ch;
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_ch    = '0;
        e_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_ready_low", 0, 64'(rdy_w[0]), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rel_ready", g, 64'(rdy_w[g]), 64'd1);
            chk("rel_valid", g, 64'(val_w[g]), 64'd0);
            chk("rel_data", g, 64'(dat_w[g]), 64'd0);
            chk("rel_chan", g, 64'(ch_w[g]), 64'd0);
            chk("rel_sat", g, 64'(sat_w[g]), 64'd0);
        end

        // Raw window 1..4, result one edge after the last accept
        send(16'd1, 2'd0); send(16'd2, 2'd0); send(16'd3, 2'd0); send(16'd4, 2'd0);
        chk("A_not_yet", 0, 64'(val_w[0]), 64'd0);
        idle();
        chk("A_valid", 0, 64'(val_w[0]), 64'd1);
        chk("A_data", 0, 64'(dat_w[0]), 64'd10);
        chk("A_sat", 0, 64'(sat_w[0]), 64'd0);
        idle();
        chk("A_pulse", 0, 64'(val_w[0]), 64'd0);

        // Absolute value incl. most-negative sample; squares
        send(16'hFFFD, 2'd0); send(16'd5, 2'd0); send(16'h8000, 2'd0); send(16'd0, 2'd0);
        send(16'hFFFD, 2'd0);
        chk("B_abs_valid", 1, 64'(val_w[1]), 64'd1);
        chk("B_abs_data", 1, 64'(dat_w[1]), 64'd32776);
        send(16'd4, 2'd0); send(16'd0, 2'd0);
        chk("B_sq_valid", 2, 64'(val_w[2]), 64'd1);
        chk("B_sq_data", 2, 64'(dat_w[2]), 64'd25);
        chk("B_sq_sat", 2, 64'(sat_w[2]), 64'd0);
        send(16'd0, 2'd0); idle();

        // Interleaved channels, back-to-back completions
        send(16'd10, 2'd0); send(16'd20, 2'd1); send(16'd30, 2'd0); send(16'd40, 2'd1);
        chk("C_first_ch", 3, 64'(ch_w[3]), 64'd0);
        chk("C_first_data", 3, 64'(dat_w[3]), 64'd40);
        idle();
        chk("C_second_valid", 3, 64'(val_w[3]), 64'd1);
        chk("C_second_ch", 3, 64'(ch_w[3]), 64'd1);
        chk("C_second_data", 3, 64'(dat_w[3]), 64'd60);
        idle();
        chk("C_drained", 3, 64'(val_w[3]), 64'd0);

        // Backpressure across two completions
        e_ready = 1'b0;
        send(16'd1, 2'd0); send(16'd2, 2'd0); send(16'd3, 2'd1); send(16'd4, 2'd1);
        chk("D_stall_ready", 3, 64'(rdy_w[3]), 64'd0);
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("D_hold_valid", 3, 64'(val_w[3]), 64'd1);
            chk("D_hold_data", 3, 64'(dat_w[3]), 64'd3);
            chk("D_hold_ch", 3, 64'(ch_w[3]), 64'd0);
        end
        e_ready = 1'b1;
        #1;
        chk("D_release_ready", 3, 64'(rdy_w[3]), 64'd1);
        tick();
        chk("D_second_valid", 3, 64'(val_w[3]), 64'd1);
        chk("D_second_data", 3, 64'(dat_w[3]), 64'd7);
        chk("D_second_ch", 3, 64'(ch_w[3]), 64'd1);
        idle();

        // Saturation, then a clean window on the same channel
        send(16'hFFFF, 2'd0); send(16'h0002, 2'd0); send(16'd1, 2'd0);
        chk("E_sat_data", 3, 64'(dat_w[3]), 64'hFFFF);
        chk("E_sat_flag", 3, 64'(sat_w[3]), 64'd1);
        send(16'd1, 2'd0); idle();
        chk("E_clean_data", 3, 64'(dat_w[3]), 64'd2);
        chk("E_clean_flag", 3, 64'(sat_w[3]), 64'd0);
        idle();

        // Reset mid-window drops the partial sum
        send(16'd5, 2'd0); send(16'd5, 2'd0);
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        chk("F_rst_valid", 0, 64'(val_w[0]), 64'd0);
        chk("F_rst_ready", 0, 64'(rdy_w[0]), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        chk("F_no_pulse", 0, 64'(val_w[0]), 64'd0);
        for (int k = 0; k < 4; k++) send(16'd1, 2'd0);
        idle();
        chk("F_fresh_data", 0, 64'(dat_w[0]), 64'd4);

        // Randomized traffic with varying consumer behaviour
        for (int n = 0; n < 4000; n++) begin
            case ((n / 150) % 3)
                0:       e_ready = 1'b1;
                1:       e_ready = 1'($urandom_range(0, 1));
                default: e_ready = ($urandom_range(0, 7) == 0);
            endcase
            s_valid = ($urandom_range(0, 9) < 7);
            s_ch    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       s_data = 16'h8000;
                1:       s_data = 16'h7FFF;
                2:       s_data = 16'hFFFF;
                3:       s_data = 16'h0000;
                4:       s_data = 16'h0080;
                default: s_data = 16'($urandom);
            endcase
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        s_valid = 1'b0;
        e_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
